// File: rtl/mem_alu_unit_if.sv
// Signal bundle between the control/datapath side and the memory-and-ALU slice.
// Names follow the datapath's established signal naming.
interface mem_alu_unit_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_W     = 32
);
    logic                  Read;
    logic                  Write;
    logic                  MDR_enable;
    logic [DATA_W-1:0]     bus_in;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]     Y_in;
    logic [4:0]            opcode;
    logic                  IncPC;
    logic                  branch_flag;
    logic [DATA_W-1:0]     MDR_out;
    logic [DATA_W-1:0]     RAM_out;
    logic [DATA_W-1:0]     C_out_HI;
    logic [DATA_W-1:0]     C_out_LO;

    modport master (
        output Read, Write, MDR_enable, bus_in, addr, Y_in, opcode, IncPC, branch_flag,
        input  MDR_out, RAM_out, C_out_HI, C_out_LO
    );

    modport slave (
        input  Read, Write, MDR_enable, bus_in, addr, Y_in, opcode, IncPC, branch_flag,
        output MDR_out, RAM_out, C_out_HI, C_out_LO
    );
endinterface

// File: rtl/mem_alu_unit.sv
// Memory-and-arithmetic slice: MDR register, 512x32 RAM with asynchronous read,
// and the combinational ALU producing the HI/LO result halves and PC arithmetic.
module mem_alu_unit #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int DATA_W     = 32
) (
    input  logic          clk,
    input  logic          clr,
    mem_alu_unit_if.slave dp
);

    typedef enum logic [4:0] {
        OP_LD   = 5'd0,
        OP_LDI  = 5'd1,
        OP_ST   = 5'd2,
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_SHR  = 5'd5,
        OP_SHRA = 5'd6,
        OP_SHL  = 5'd7,
        OP_ROR  = 5'd8,
        OP_ROL  = 5'd9,
        OP_AND  = 5'd10,
        OP_OR   = 5'd11,
        OP_ADDI = 5'd12,
        OP_ANDI = 5'd13,
        OP_ORI  = 5'd14,
        OP_MUL  = 5'd15,
        OP_DIV  = 5'd16,
        OP_NEG  = 5'd17,
        OP_NOT  = 5'd18,
        OP_BR   = 5'd19,
        OP_JR   = 5'd20,
        OP_JAL  = 5'd21,
        OP_IN   = 5'd22,
        OP_OUT  = 5'd23,
        OP_MFHI = 5'd24,
        OP_MFLO = 5'd25,
        OP_NOP  = 5'd26,
        OP_HALT = 5'd27
    } alu_op_e;

    localparam logic [DATA_W-1:0] ONE   = 1;
    localparam logic [5:0]        WIDTH = 6'd32;

    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [2*DATA_W-1:0] alu_res;

    // Signed divide done on magnitudes so the most-negative / -1 case wraps
    // cleanly instead of relying on the tool's signed-overflow behaviour.
    function automatic logic [2*DATA_W-1:0] div_eval(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] ua;
        logic [DATA_W-1:0] ub;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        if (b == '0) begin
            return {a, {DATA_W{1'b0}}};
        end
        ua = a[DATA_W-1] ? -a : a;
        ub = b[DATA_W-1] ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        if (a[DATA_W-1] ^ b[DATA_W-1]) begin
            q = -q;
        end
        if (a[DATA_W-1]) begin
            r = -r;
        end
        return {r, q};
    endfunction

    function automatic logic [2*DATA_W-1:0] alu_eval(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic [4:0]               op,
        input logic                     inc,
        input logic                     bf
    );
        logic [DATA_W-1:0]          hi;
        logic [DATA_W-1:0]          lo;
        logic [4:0]                 sh;
        logic signed [2*DATA_W-1:0] prod;
        hi   = '0;
        lo   = '0;
        sh   = b[4:0];
        prod = '0;
        if (inc) begin
            lo = b + ONE;
        end else begin
            case (alu_op_e'(op))
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: lo = a + b;
                OP_SUB:  lo = a - b;
                OP_SHR:  lo = a >> sh;
                OP_SHRA: lo = a >>> sh;
                OP_SHL:  lo = a << sh;
                // A shift by the full width yields zero, so sh=0 rotates to A.
                OP_ROR:  lo = (a >> sh) | (a << (WIDTH - {1'b0, sh}));
                OP_ROL:  lo = (a << sh) | (a >> (WIDTH - {1'b0, sh}));
                OP_AND, OP_ANDI: lo = a & b;
                OP_OR, OP_ORI:   lo = a | b;
                OP_MUL: begin
                    prod     = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
                               $signed({{DATA_W{b[DATA_W-1]}}, b});
                    {hi, lo} = prod;
                end
                OP_DIV:  {hi, lo} = div_eval(a, b);
                OP_NEG:  lo = -b;
                OP_NOT:  lo = ~b;
                OP_BR:   lo = bf ? a + b : a;
                OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: lo = b;
                default: lo = '0;
            endcase
        end
        return {hi, lo};
    endfunction

    assign ram_rd = mem[dp.addr];

    // MDR: bus or RAM capture, cleared asynchronously by clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mdr_q <= '0;
        end else if (dp.MDR_enable) begin
            mdr_q <= dp.Read ? ram_rd : dp.bus_in;
        end
    end

    // RAM write port stores the current MDR; unaffected by clr.
    always_ff @(posedge clk) begin
        if (dp.Write) begin
            mem[dp.addr] <= mdr_q;
        end
    end

    always_comb begin
        alu_res = '0;
        alu_res = alu_eval(dp.Y_in, dp.bus_in, dp.opcode, dp.IncPC, dp.branch_flag);
    end

    assign dp.MDR_out  = mdr_q;
    assign dp.RAM_out  = ram_rd;
    assign dp.C_out_HI = alu_res[2*DATA_W-1:DATA_W];
    assign dp.C_out_LO = alu_res[DATA_W-1:0];

endmodule

// File: tb/tb_mem_alu_unit.sv
// Bench for mem_alu_unit: directed cases plus randomized ALU and memory traffic
// compared against a behavioural model of the MDR, RAM and ALU.
module tb_mem_alu_unit;

    logic clk;
    logic clr;
    int   n_vec;
    int   n_bad;

    bit [31:0] ref_mem [512];
    bit [31:0] ref_mdr;

    mem_alu_unit_if #(.ADDR_WIDTH(9), .DATA_W(32)) dp ();

    mem_alu_unit u_dut (
        .clk (clk),
        .clr (clr),
        .dp  (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic bit [63:0] ref_alu(input bit [31:0] a, input bit [31:0] b,
                                          input bit [4:0] op, input bit inc, input bit bf);
        int         sa;
        int         sb;
        int         n;
        int         t;
        longint     p;
        longint     q;
        longint     r;
        bit [63:0]  w;
        bit [63:0]  wr;
        bit [31:0]  lo;
        bit [31:0]  hi;
        sa = int'(a);
        sb = int'(b);
        n  = int'(b[4:0]);
        hi = 0;
        lo = 0;
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
            5'd4:  lo = a - b;
            5'd5:  lo = a >> n;
            5'd6:  begin t = sa >>> n; lo = t; end
            5'd7:  lo = a << n;
            5'd8:  begin w = {a, a}; w = w >> n; lo = w[31:0]; end
            5'd9:  begin w = {a, a}; w = w << n; lo = w[63:32]; end
            5'd10, 5'd13: lo = a & b;
            5'd11, 5'd14: lo = a | b;
            5'd15: begin p = longint'(sa) * longint'(sb); w = p; {hi, lo} = w; end
            5'd16: begin
                if (b == 0) begin
                    lo = 0;
                    hi = a;
                end else begin
                    q  = longint'(sa) / longint'(sb);
                    r  = longint'(sa) % longint'(sb);
                    w  = q;
                    wr = r;
                    lo = w[31:0];
                    hi = wr[31:0];
                end
            end
            5'd17: lo = 32'd0 - b;
            5'd18: lo = ~b;
            5'd19: lo = bf ? a + b : a;
            5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25: lo = b;
            default: lo = 0;
        endcase
        return {hi, lo};
    endfunction

    // Advance one clock edge, updating the model from the inputs in force before it.
    task automatic tick();
        bit [31:0] nxt;
        if (!clr) ref_mdr = 0;
        nxt = ref_mdr;
        if (!clr) nxt = 0;
        else if (dp.MDR_enable) nxt = dp.Read ? ref_mem[dp.addr] : dp.bus_in;
        if (dp.Write) ref_mem[dp.addr] = ref_mdr;
        ref_mdr = nxt;
        @(posedge clk);
        #1;
        check_val("mdr", {32'd0, dp.MDR_out}, {32'd0, ref_mdr});
        check_val("ram_rd", {32'd0, dp.RAM_out}, {32'd0, ref_mem[dp.addr]});
    endtask

    task automatic apply_alu(input bit [31:0] a, input bit [31:0] b, input bit [4:0] op,
                             input bit inc, input bit bf);
        dp.MDR_enable  = 1'b0;
        dp.Write       = 1'b0;
        dp.Y_in        = a;
        dp.bus_in      = b;
        dp.opcode      = op;
        dp.IncPC       = inc;
        dp.branch_flag = bf;
        #1;
    endtask

    task automatic alu_directed(input string tag, input bit [31:0] a, input bit [31:0] b,
                                input bit [4:0] op, input bit inc, input bit bf,
                                input bit [31:0] exp_hi, input bit [31:0] exp_lo);
        apply_alu(a, b, op, inc, bf);
        check_val(tag, {dp.C_out_HI, dp.C_out_LO}, {exp_hi, exp_lo});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        ref_mdr = 0;
        foreach (ref_mem[i]) ref_mem[i] = 0;
        clr            = 1'b0;
        dp.Read        = 1'b0;
        dp.Write       = 1'b0;
        dp.MDR_enable  = 1'b0;
        dp.bus_in      = '0;
        dp.addr        = '0;
        dp.Y_in        = '0;
        dp.opcode      = '0;
        dp.IncPC       = 1'b0;
        dp.branch_flag = 1'b0;
        #2;
        check_val("reset_mdr", {32'd0, dp.MDR_out}, 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;

        // Store then load back through the RAM
        dp.MDR_enable = 1'b1; dp.Read = 1'b0; dp.bus_in = 32'hDEADBEEF;
        tick();
        check_val("mdr_bus", {32'd0, dp.MDR_out}, {32'd0, 32'hDEADBEEF});
        dp.MDR_enable = 1'b0; dp.Write = 1'b1; dp.addr = 9'h055;
        tick();
        dp.Write = 1'b0; dp.MDR_enable = 1'b1; dp.bus_in = 32'h0;
        tick();
        dp.Read = 1'b1;
        tick();
        check_val("load_back", {32'd0, dp.MDR_out}, {32'd0, 32'hDEADBEEF});
        dp.MDR_enable = 1'b0; dp.Read = 1'b0; dp.addr = 9'h1FF;
        #1;
        check_val("ram_top_zero", {32'd0, dp.RAM_out}, 64'd0);

        // Same-edge write and read: MDR takes the pre-write word
        dp.addr = 9'h0AA; dp.Write = 1'b1; dp.Read = 1'b1; dp.MDR_enable = 1'b1;
        tick();
        check_val("rw_mdr_old", {32'd0, dp.MDR_out}, 64'd0);
        check_val("rw_ram_new", {32'd0, dp.RAM_out}, {32'd0, 32'hDEADBEEF});

        // Asynchronous clear in mid-cycle, held across enabled edges
        dp.Write = 1'b0; dp.Read = 1'b0; dp.bus_in = 32'h12345678;
        tick();
        #2;
        clr = 1'b0;
        ref_mdr = 0;
        #1;
        check_val("clr_async", {32'd0, dp.MDR_out}, 64'd0);
        tick();
        tick();
        clr = 1'b1;
        tick();
        check_val("clr_release_load", {32'd0, dp.MDR_out}, {32'd0, 32'h12345678});

        // Directed ALU cases
        alu_directed("add",  32'h5, 32'h7, 5'd3,  1'b0, 1'b0, 32'h0, 32'h0000000C);
        alu_directed("sub",  32'h5, 32'h7, 5'd4,  1'b0, 1'b0, 32'h0, 32'hFFFFFFFE);
        alu_directed("and",  32'h5, 32'h7, 5'd10, 1'b0, 1'b0, 32'h0, 32'h00000005);
        alu_directed("shr",  32'h80000001, 32'd5, 5'd5, 1'b0, 1'b0, 32'h0, 32'h04000000);
        alu_directed("shra", 32'h80000001, 32'd5, 5'd6, 1'b0, 1'b0, 32'h0, 32'hFC000000);
        alu_directed("shl",  32'h80000001, 32'd5, 5'd7, 1'b0, 1'b0, 32'h0, 32'h00000020);
        alu_directed("ror",  32'h80000001, 32'd5, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0C000000);
        alu_directed("rol",  32'h80000001, 32'd5, 5'd9, 1'b0, 1'b0, 32'h0, 32'h00000030);
        alu_directed("mul",  32'hFFFFFFFE, 32'd3, 5'd15, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        alu_directed("div",  32'hFFFFFFF9, 32'd2, 5'd16, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        alu_directed("div0", 32'd9, 32'd0, 5'd16, 1'b0, 1'b0, 32'd9, 32'd0);
        alu_directed("incpc", 32'h1234, 32'h10, 5'd15, 1'b1, 1'b0, 32'h0, 32'h11);
        alu_directed("br_t", 32'h20, 32'h05, 5'd19, 1'b0, 1'b1, 32'h0, 32'h25);
        alu_directed("br_nt", 32'h20, 32'h05, 5'd19, 1'b0, 1'b0, 32'h0, 32'h20);
        alu_directed("div_ovf", 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b0, 1'b0, 32'h0, 32'h80000000);
        alu_directed("halt", 32'h5, 32'h7, 5'd27, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized ALU traffic
        for (int i = 0; i < 400; i++) begin
            bit [31:0] a;
            bit [31:0] b;
            bit [4:0]  op;
            bit        inc;
            bit        bf;
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            op  = 5'($urandom_range(0, 31));
            inc = ($urandom_range(0, 9) == 0);
            bf  = 1'($urandom_range(0, 1));
            apply_alu(a, b, op, inc, bf);
            check_val("alu_rand", {dp.C_out_HI, dp.C_out_LO}, ref_alu(a, b, op, inc, bf));
        end

        // Randomized memory traffic, including occasional clears
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            dp.addr       = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
            dp.Write      = 1'($urandom_range(0, 1));
            dp.Read       = 1'($urandom_range(0, 1));
            dp.MDR_enable = ($urandom_range(0, 9) < 7);
            dp.bus_in     = $urandom;
            clr           = ($urandom_range(0, 19) != 0);
            tick();
        end
        clr = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
